mix_column: RTL and testbench



---
 rtl/aes_pkg.sv | 15 +
 rtl/gf_mul_const.sv | 33 +++
 rtl/mix_column.sv | 87 ++++++++
 tb/tb_mix_column.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: byte/column types, reduction constant, xtime.
package aes_pkg;

    typedef logic [7:0]  aes_byte_t;
    typedef logic [31:0] aes_col_t;

    // Low byte of the field polynomial x^8+x^4+x^3+x+1.
    localparam aes_byte_t AES_POLY_LOW = 8'h1B;

    // Multiply by x in GF(2^8): shift left and fold the carry back in.
    function automatic aes_byte_t xtime(input aes_byte_t a);
        xtime = {a[6:0], 1'b0} ^ (a[7] ? AES_POLY_LOW : 8'h00);
    endfunction

endpackage

// File: rtl/gf_mul_const.sv
// Constant GF(2^8) multiples of one byte, built from xtime chains.
module gf_mul_const
    import aes_pkg::*;
(
    input  aes_byte_t a,
    output aes_byte_t p1,
    output aes_byte_t p2,
    output aes_byte_t p3,
    output aes_byte_t p9,
    output aes_byte_t pb,
    output aes_byte_t pd,
    output aes_byte_t pe
);

    aes_byte_t x2;
    aes_byte_t x4;
    aes_byte_t x8;

    // Powers of two by repeated xtime, then the odd multiples as XOR sums.
    always_comb begin
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        p1 = a;
        p2 = x2;
        p3 = x2 ^ a;
        p9 = x8 ^ a;
        pb = x8 ^ x2 ^ a;
        pd = x8 ^ x4 ^ a;
        pe = x8 ^ x4 ^ x2;
    end

endmodule

// File: rtl/mix_column.sv
// AES MixColumns / InvMixColumns on one column, registered output (1-cycle latency).
module mix_column
    import aes_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        inv,
    input  logic [31:0] in,
    output logic [31:0] out,
    output logic        out_valid
);

    aes_byte_t a  [4];
    aes_byte_t m1 [4];
    aes_byte_t m2 [4];
    aes_byte_t m3 [4];
    aes_byte_t m9 [4];
    aes_byte_t mb [4];
    aes_byte_t md [4];
    aes_byte_t me [4];

    aes_col_t fwd_p0;
    aes_col_t inv_p0;
    aes_col_t col_p1_d;
    aes_col_t col_p1_q;
    logic     vld_p1_d;
    logic     vld_p1_q;

    // Byte 0 (row 0) sits in the top byte of the column.
    assign a[0] = in[31:24];
    assign a[1] = in[23:16];
    assign a[2] = in[15:8];
    assign a[3] = in[7:0];

    for (genvar i = 0; i < 4; i++) begin : g_byte
        gf_mul_const u_mul (
            .a  (a[i]),
            .p1 (m1[i]),
            .p2 (m2[i]),
            .p3 (m3[i]),
            .p9 (m9[i]),
            .pb (mb[i]),
            .pd (md[i]),
            .pe (me[i])
        );
    end

    // Circulant XOR networks for both directions; row i uses a_i, a_i+1, a_i+2, a_i+3.
    always_comb begin
        fwd_p0[31:24] = m2[0] ^ m3[1] ^ m1[2] ^ m1[3];
        fwd_p0[23:16] = m2[1] ^ m3[2] ^ m1[3] ^ m1[0];
        fwd_p0[15:8]  = m2[2] ^ m3[3] ^ m1[0] ^ m1[1];
        fwd_p0[7:0]   = m2[3] ^ m3[0] ^ m1[1] ^ m1[2];

        inv_p0[31:24] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
        inv_p0[23:16] = me[1] ^ mb[2] ^ md[3] ^ m9[0];
        inv_p0[15:8]  = me[2] ^ mb[3] ^ md[0] ^ m9[1];
        inv_p0[7:0]   = me[3] ^ mb[0] ^ md[1] ^ m9[2];
    end

    // Select direction and hold the previous result when no column is offered,
    // so an undriven input bus never reaches the register.
    always_comb begin
        col_p1_d = col_p1_q;
        vld_p1_d = in_valid;
        if (in_valid) begin
            col_p1_d = inv ? inv_p0 : fwd_p0;
        end
    end

    // ---- stage boundary: p0 combinational -> p1 output register ----
    // Output register; reset clears both result and valid immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_p1_q <= '0;
            vld_p1_q <= 1'b0;
        end else begin
            col_p1_q <= col_p1_d;
            vld_p1_q <= vld_p1_d;
        end
    end

    assign out       = col_p1_q;
    assign out_valid = vld_p1_q;

endmodule

// File: tb/tb_mix_column.sv
// Self-checking bench for mix_column against a matrix-product GF(2^8) model.
module tb_mix_column;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        inv;
    logic [31:0] in;
    logic [31:0] out;
    logic        out_valid;

    int n_checks;
    int n_fail;

    mix_column dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .inv       (inv),
        .in        (in),
        .out       (out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // General shift-and-add multiply in GF(2^8) mod 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] acc;
        acc = '0;
        for (int k = 0; k < 8; k++)
            if (y[k]) acc = acc ^ (16'(x) << k);
        for (int k = 15; k >= 8; k--)
            if (acc[k]) acc = acc ^ (16'h011B << (k - 8));
        return acc[7:0];
    endfunction

    // Column times the circulant matrix whose first row is c.
    function automatic logic [31:0] ref_mix(input logic [31:0] col, input logic do_inv);
        logic [7:0] c [4];
        logic [7:0] av [4];
        logic [7:0] bv [4];
        if (do_inv) begin
            c[0] = 8'h0E; c[1] = 8'h0B; c[2] = 8'h0D; c[3] = 8'h09;
        end else begin
            c[0] = 8'h02; c[1] = 8'h03; c[2] = 8'h01; c[3] = 8'h01;
        end
        for (int i = 0; i < 4; i++) av[i] = col[31 - 8*i -: 8];
        for (int i = 0; i < 4; i++) begin
            bv[i] = 8'h00;
            for (int k = 0; k < 4; k++) bv[i] = bv[i] ^ gmul(c[k], av[(i + k) % 4]);
        end
        return {bv[0], bv[1], bv[2], bv[3]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Present one input for a cycle and return just after the capturing edge.
    task automatic step(input logic v, input logic i_inv, input logic [31:0] d);
        in_valid = v;
        inv      = i_inv;
        in       = d;
        @(posedge clk);
        #1;
    endtask

    typedef struct { logic [31:0] din; logic md; logic [31:0] dout; } vec_t;
    vec_t vecs [$];

    logic [31:0] held;
    logic [31:0] x;
    logic [31:0] y;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        inv      = 1'b0;
        in       = '0;
        #2;
        check("reset_out", out, 32'h0);
        check("reset_vld", {31'b0, out_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        vecs.push_back('{32'hd4bf5d30, 1'b0, 32'h046681e5});
        vecs.push_back('{32'hdb135345, 1'b0, 32'h8e4da1bc});
        vecs.push_back('{32'hf20a225c, 1'b0, 32'h9fdc589d});
        vecs.push_back('{32'h2d26314c, 1'b0, 32'h4d7ebdf8});
        vecs.push_back('{32'hd4d4d4d5, 1'b0, 32'hd5d5d7d6});
        vecs.push_back('{32'h046681e5, 1'b1, 32'hd4bf5d30});
        vecs.push_back('{32'h8e4da1bc, 1'b1, 32'hdb135345});
        for (int m = 0; m < 2; m++) begin
            vecs.push_back('{32'h00000000, m[0], 32'h00000000});
            vecs.push_back('{32'hc6c6c6c6, m[0], 32'hc6c6c6c6});
            vecs.push_back('{32'h01010101, m[0], 32'h01010101});
        end

        // Known vectors, each separated by an idle cycle.
        foreach (vecs[i]) begin
            step(1'b1, vecs[i].md, vecs[i].din);
            check($sformatf("vec%0d_out", i), out, vecs[i].dout);
            check($sformatf("vec%0d_vld", i), {31'b0, out_valid}, 32'h1);
            check($sformatf("vec%0d_model", i), ref_mix(vecs[i].din, vecs[i].md), vecs[i].dout);
            step(1'b0, ~vecs[i].md, $urandom);
            check($sformatf("vec%0d_idle_vld", i), {31'b0, out_valid}, 32'h0);
            check($sformatf("vec%0d_idle_hold", i), out, vecs[i].dout);
        end

        // Back-to-back stream with alternating direction.
        step(1'b1, 1'b0, 32'hd4bf5d30);
        check("strm0_out", out, 32'h046681e5);
        check("strm0_vld", {31'b0, out_valid}, 32'h1);
        step(1'b1, 1'b1, 32'h046681e5);
        check("strm1_out", out, 32'hd4bf5d30);
        check("strm1_vld", {31'b0, out_valid}, 32'h1);
        step(1'b1, 1'b0, 32'hdb135345);
        check("strm2_out", out, 32'h8e4da1bc);
        check("strm2_vld", {31'b0, out_valid}, 32'h1);
        step(1'b0, 1'b1, 32'hffffffff);
        check("strm_idle_vld", {31'b0, out_valid}, 32'h0);
        check("strm_idle_out", out, 32'h8e4da1bc);

        // Asynchronous reset in the middle of a cycle.
        step(1'b1, 1'b0, 32'hf20a225c);
        check("prerst_out", out, 32'h9fdc589d);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out", out, 32'h0);
        check("arst_vld", {31'b0, out_valid}, 32'h0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_vld", {31'b0, out_valid}, 32'h0);
        check("postrst_out", out, 32'h0);
        step(1'b1, 1'b0, 32'h2d26314c);
        check("postrst_first", out, 32'h4d7ebdf8);
        check("postrst_first_vld", {31'b0, out_valid}, 32'h1);

        // Random round trips: forward against the model, then inverse must recover.
        for (int r = 0; r < 1000; r++) begin
            x = $urandom;
            step(1'b1, 1'b0, x);
            y = out;
            check("rnd_fwd", y, ref_mix(x, 1'b0));
            step(1'b1, 1'b1, y);
            check("rnd_inv", out, x);
            if ((r % 7) == 0) begin
                held = out;
                step(1'b0, 1'b0, $urandom);
                check("rnd_idle_hold", out, held);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a stuck simulation.
    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
